// File: rtl/alu_arbiter_if.sv
// Requester/responder bundle shared by two clients of one ALU.
// master = requester side, slave = the arbiter.
interface alu_arbiter_if #(
  parameter int WIDTH = 32
);
  logic             req0_valid;
  logic             req0_ready;
  logic [WIDTH-1:0] req0_a;
  logic [WIDTH-1:0] req0_b;
  logic [3:0]       req0_sel;
  logic             req1_valid;
  logic             req1_ready;
  logic [WIDTH-1:0] req1_a;
  logic [WIDTH-1:0] req1_b;
  logic [3:0]       req1_sel;
  logic             rsp0_valid;
  logic             rsp0_ready;
  logic             rsp1_valid;
  logic             rsp1_ready;
  logic [WIDTH-1:0] rsp_data;
  logic             rsp_carry;

  modport master (
    output req0_valid, req0_a, req0_b, req0_sel,
    output req1_valid, req1_a, req1_b, req1_sel,
    output rsp0_ready, rsp1_ready,
    input  req0_ready, req1_ready, rsp0_valid, rsp1_valid, rsp_data, rsp_carry
  );

  modport slave (
    input  req0_valid, req0_a, req0_b, req0_sel,
    input  req1_valid, req1_a, req1_b, req1_sel,
    input  rsp0_ready, rsp1_ready,
    output req0_ready, req1_ready, rsp0_valid, rsp1_valid, rsp_data, rsp_carry
  );
endinterface

// File: rtl/alu_arbiter.sv
// Shares one combinational ALU between two requesters: IDLE -> EXEC -> RESP.
// Define ALU_ARB_FIXED_PRIO_EN for fixed priority (requester 0 wins ties); default is round-robin.
module alu_arbiter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  alu_arbiter_if.slave     bus,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [3:0]       alu_sel,
  input  logic [WIDTH-1:0] alu_out,
  input  logic             alu_carry,
  output logic [15:0]      op_count
);
  typedef enum logic [1:0] {S_IDLE, S_EXEC, S_RESP} state_t;

  state_t           state;
  state_t           state_next;
  logic             grant_id;
  logic             grant_next;
  logic             any_valid;
  logic             accept;
  logic             rsp_fire;
  logic             req0_ready;
  logic             req1_ready;
  logic             rsp0_valid;
  logic             rsp1_valid;
  logic [WIDTH-1:0] rsp_data_q;
  logic             rsp_carry_q;
  logic [15:0]      op_count_q;

  assign any_valid = bus.req0_valid | bus.req1_valid;

  // NOTE: sequential state uses non-blocking (<=) so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_next;
  end

  // NOTE: every always_comb output gets a default first so no path infers a latch.
  always_comb begin
    state_next = state;
    accept     = 1'b0;
    rsp_fire   = 1'b0;
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    rsp0_valid = 1'b0;
    rsp1_valid = 1'b0;
    case (state)
      S_IDLE: begin
        // rst_n gates ready so the outputs read zero while reset is held.
        if (any_valid && rst_n) begin
          accept     = 1'b1;
          req0_ready = ~grant_next;
          req1_ready = grant_next;
          state_next = S_EXEC;
        end
      end
      S_EXEC: state_next = S_RESP;
      S_RESP: begin
        rsp0_valid = ~grant_id;
        rsp1_valid = grant_id;
        rsp_fire   = grant_id ? bus.rsp1_ready : bus.rsp0_ready;
        if (rsp_fire) state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

`ifdef ALU_ARB_FIXED_PRIO_EN
  assign grant_next = ~bus.req0_valid;
`else
  logic rr_ptr;

  // The pointer only breaks ties; a lone requester wins outright, yet still moves it.
  assign grant_next = (bus.req0_valid && bus.req1_valid) ? rr_ptr : bus.req1_valid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      rr_ptr <= 1'b0;
    else if (accept) rr_ptr <= ~grant_next;
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      grant_id    <= 1'b0;
      alu_a       <= '0;
      alu_b       <= '0;
      alu_sel     <= '0;
      rsp_data_q  <= '0;
      rsp_carry_q <= 1'b0;
      op_count_q  <= '0;
    end else begin
      if (accept) begin
        grant_id <= grant_next;
        alu_a    <= grant_next ? bus.req1_a   : bus.req0_a;
        alu_b    <= grant_next ? bus.req1_b   : bus.req0_b;
        alu_sel  <= grant_next ? bus.req1_sel : bus.req0_sel;
      end
      if (state == S_EXEC) begin
        rsp_data_q  <= alu_out;
        rsp_carry_q <= alu_carry;
      end
      if (rsp_fire && (op_count_q != 16'hFFFF)) op_count_q <= op_count_q + 16'd1;
    end
  end

  assign bus.req0_ready = req0_ready;
  assign bus.req1_ready = req1_ready;
  assign bus.rsp0_valid = rsp0_valid;
  assign bus.rsp1_valid = rsp1_valid;
  assign bus.rsp_data   = rsp_data_q;
  assign bus.rsp_carry  = rsp_carry_q;
  assign op_count       = op_count_q;
endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: vector table, hand-written corner sequences and a randomized
// phase against a transaction-level reference model; also drives a combinational ALU.
`timescale 1ns/1ps
module tb_alu_arbiter;
  localparam int WIDTH = 32;
  localparam logic [3:0] OP_AND = 4'd0, OP_OR = 4'd1, OP_ADD = 4'd2;
  localparam logic [3:0] OP_SUB = 4'd6, OP_SLT = 4'd7, OP_NOR = 4'd12;

  typedef struct {
    logic             v0;
    logic             v1;
    logic [WIDTH-1:0] a0;
    logic [WIDTH-1:0] b0;
    logic [3:0]       s0;
    logic [WIDTH-1:0] a1;
    logic [WIDTH-1:0] b1;
    logic [3:0]       s1;
    logic             gnt;
    logic [WIDTH-1:0] data;
    logic             carry;
  } vec_t;

  logic             clk   = 1'b0;
  logic             rst_n = 1'b0;
  logic [WIDTH-1:0] alu_a;
  logic [WIDTH-1:0] alu_b;
  logic [3:0]       alu_sel;
  logic [WIDTH-1:0] alu_out;
  logic             alu_carry;
  logic [15:0]      op_count;
  int               checks   = 0;
  int               failures = 0;
  logic [15:0]      exp_count;
  vec_t             vecs [7];
  logic [3:0]       sel_tab [7];

  always #5 clk = ~clk;

  alu_arbiter_if #(.WIDTH(WIDTH)) bus ();

  alu_arbiter #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus.slave),
    .alu_a     (alu_a),
    .alu_b     (alu_b),
    .alu_sel   (alu_sel),
    .alu_out   (alu_out),
    .alu_carry (alu_carry),
    .op_count  (op_count)
  );

  // Shared ALU: {carry, result}; subtraction carry is the carry-out of a + ~b + 1.
  function automatic logic [WIDTH:0] alu_fn(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                            input logic [3:0] sel);
    case (sel)
      OP_AND:  return {1'b0, a & b};
      OP_OR:   return {1'b0, a | b};
      OP_ADD:  return {1'b0, a} + {1'b0, b};
      OP_SUB:  return {1'b0, a} + {1'b0, ~b} + (WIDTH+1)'(1);
      OP_SLT:  return {{WIDTH{1'b0}}, ($signed(a) < $signed(b))};
      OP_NOR:  return {1'b0, ~(a | b)};
      default: return {1'b0, a};
    endcase
  endfunction

  assign {alu_carry, alu_out} = alu_fn(alu_a, alu_b, alu_sel);

  function automatic logic [15:0] sat_inc(input logic [15:0] c);
    return (c == 16'hFFFF) ? c : c + 16'd1;
  endfunction

  function automatic vec_t mk(input logic v0, input logic v1,
                              input logic [WIDTH-1:0] a0, input logic [WIDTH-1:0] b0, input logic [3:0] s0,
                              input logic [WIDTH-1:0] a1, input logic [WIDTH-1:0] b1, input logic [3:0] s1,
                              input logic gnt, input logic [WIDTH-1:0] data, input logic carry);
    vec_t v;
    v.v0 = v0; v.v1 = v1; v.a0 = a0; v.b0 = b0; v.s0 = s0;
    v.a1 = a1; v.b1 = b1; v.s1 = s1; v.gnt = gnt; v.data = data; v.carry = carry;
    return v;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.req0_valid = 1'b0; bus.req0_a = '0; bus.req0_b = '0; bus.req0_sel = '0;
    bus.req1_valid = 1'b0; bus.req1_a = '0; bus.req1_b = '0; bus.req1_sel = '0;
    bus.rsp0_ready = 1'b0; bus.rsp1_ready = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_flags"}, 64'({bus.req0_ready, bus.req1_ready, bus.rsp0_valid, bus.rsp1_valid, bus.rsp_carry}), 64'd0);
    check({tag, "_alu_a"}, 64'(alu_a), 64'd0);
    check({tag, "_alu_b_sel"}, 64'({alu_b, alu_sel}), 64'd0);
    check({tag, "_data_count"}, 64'({bus.rsp_data, op_count}), 64'd0);
  endtask

  // Requests stay asserted through reset to show ready is held low regardless.
  task automatic do_reset();
    idle_inputs();
    bus.req0_valid = 1'b1;
    bus.req1_valid = 1'b1;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_all_zero("reset");
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
    rst_n     = 1'b1;
    exp_count = 16'd0;
  endtask

  // One complete operation from IDLE with both response readies high.
  task automatic run_op(input vec_t v, input string tag);
    logic [1:0] gpair;
    gpair = v.gnt ? 2'b01 : 2'b10;
    bus.req0_valid = v.v0; bus.req0_a = v.a0; bus.req0_b = v.b0; bus.req0_sel = v.s0;
    bus.req1_valid = v.v1; bus.req1_a = v.a1; bus.req1_b = v.b1; bus.req1_sel = v.s1;
    bus.rsp0_ready = 1'b1; bus.rsp1_ready = 1'b1;
    #1;
    check({tag, "_grant"}, 64'({bus.req0_ready, bus.req1_ready}), 64'(gpair));
    tick();
    check({tag, "_exec"}, 64'({bus.req0_ready, bus.req1_ready, bus.rsp0_valid, bus.rsp1_valid}), 64'd0);
    tick();
    check({tag, "_rsp_valid"}, 64'({bus.req0_ready, bus.req1_ready, bus.rsp0_valid, bus.rsp1_valid}),
          64'({2'b00, gpair}));
    check({tag, "_rsp_data"}, 64'({bus.rsp_carry, bus.rsp_data}), 64'({v.carry, v.data}));
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
    tick();
    exp_count = sat_inc(exp_count);
    check({tag, "_count"}, 64'({bus.rsp0_valid, bus.rsp1_valid, op_count}), 64'({2'b00, exp_count}));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic             gnt_q [4];
    int               acc_c [4];
    int               n;
    logic             busy, ptr, m_id, v0, v1, r0, r1, g, accept_now, resp_now;
    int               acc_cyc;
    logic [WIDTH:0]   m_res;
    logic [WIDTH-1:0] m_a, m_b;
    logic [3:0]       m_sel;
    logic [1:0]       exp_rdy, exp_rv;

    sel_tab = '{OP_AND, OP_OR, OP_ADD, OP_SUB, OP_SLT, OP_NOR, 4'd5};
    vecs[0] = mk(1, 0, 'h0A, 'h02, OP_OR,  0, 0, OP_AND, 0, 'h0A, 0);
    vecs[1] = mk(0, 1, 0, 0, OP_AND, 'hFFFF_FFFF, 'h1, OP_ADD, 1, 'h0, 1);
    vecs[2] = mk(1, 1, 'h5, 'h3, OP_SUB, 'hF0, 'h0F, OP_AND, 0, 'h2, 1);
`ifdef ALU_ARB_FIXED_PRIO_EN
    vecs[3] = mk(1, 1, 'h1, 'h2, OP_ADD, 'hF0, 'h0F, OP_OR, 0, 'h3, 0);
`else
    vecs[3] = mk(1, 1, 'h1, 'h2, OP_ADD, 'hF0, 'h0F, OP_OR, 1, 'hFF, 0);
`endif
    vecs[4] = mk(1, 0, 'h12, 'h34, OP_NOR, 0, 0, OP_AND, 0, 'hFFFF_FFC9, 0);
    vecs[5] = mk(0, 1, 0, 0, OP_AND, 'h3, 'h5, OP_SLT, 1, 'h1, 0);
    vecs[6] = mk(0, 1, 0, 0, OP_AND, 'h3, 'h5, OP_SUB, 1, 'hFFFF_FFFE, 0);

    // Table: first operation is accepted on the first edge after reset release.
    do_reset();
    for (int i = 0; i < 7; i++) run_op(vecs[i], $sformatf("vec%0d", i));

    // Contention: both requesters valid continuously.
    do_reset();
    bus.req0_valid = 1'b1; bus.req0_a = 'h11; bus.req0_b = 'h22; bus.req0_sel = OP_ADD;
    bus.req1_valid = 1'b1; bus.req1_a = 'h33; bus.req1_b = 'h44; bus.req1_sel = OP_OR;
    bus.rsp0_ready = 1'b1; bus.rsp1_ready = 1'b1;
    n = 0;
    for (int c = 0; c < 20 && n < 4; c++) begin
      #1;
      if (bus.req0_ready || bus.req1_ready) begin
        gnt_q[n] = bus.req1_ready;
        acc_c[n] = c;
        n++;
      end
      tick();
    end
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
    check("contend_grants", 64'(n), 64'd4);
    for (int i = 0; i < n; i++) begin
`ifdef ALU_ARB_FIXED_PRIO_EN
      check($sformatf("contend_order%0d", i), 64'(gnt_q[i]), 64'd0);
`else
      check($sformatf("contend_order%0d", i), 64'(gnt_q[i]), 64'(i % 2));
`endif
      check($sformatf("contend_cycle%0d", i), 64'(acc_c[i]), 64'(3 * i));
    end
    tick();
    tick();
    check("contend_count", 64'(op_count), 64'd4);

    // Backpressure on requester 1; rsp0_ready held high meanwhile must be ignored.
    do_reset();
    bus.req1_valid = 1'b1; bus.req1_a = 'h100; bus.req1_b = 'h23; bus.req1_sel = OP_ADD;
    bus.rsp0_ready = 1'b1; bus.rsp1_ready = 1'b0;
    #1;
    check("bp_grant", 64'({bus.req0_ready, bus.req1_ready}), 64'b01);
    tick();
    bus.req0_valid = 1'b1;
    check("bp_exec", 64'({bus.req0_ready, bus.req1_ready}), 64'd0);
    tick();
    for (int k = 0; k < 6; k++) begin
      check("bp_hold", 64'({bus.req0_ready, bus.req1_ready, bus.rsp0_valid, bus.rsp1_valid}), 64'b0001);
      check("bp_data", 64'({bus.rsp_carry, bus.rsp_data}), 64'h123);
      check("bp_count", 64'(op_count), 64'd0);
      tick();
    end
    bus.rsp1_ready = 1'b1;
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
    tick();
    check("bp_done", 64'({bus.rsp0_valid, bus.rsp1_valid, op_count}), 64'd1);

    // Reset while a response is pending discards it.
    do_reset();
    bus.req0_valid = 1'b1; bus.req0_a = 'h7; bus.req0_b = 'h8; bus.req0_sel = OP_ADD;
    #1;
    check("rstresp_grant", 64'({bus.req0_ready, bus.req1_ready}), 64'b10);
    tick();
    tick();
    check("rstresp_pending", 64'({bus.rsp0_valid, bus.rsp1_valid, bus.rsp_data}), 64'({2'b10, 32'hF}));
    #2;
    rst_n = 1'b0;
    #1;
    check_all_zero("rstresp_async");
    @(posedge clk);
    #1;
    bus.req0_valid = 1'b0;
    bus.rsp0_ready = 1'b1;
    rst_n          = 1'b1;
    for (int k = 0; k < 5; k++) begin
      tick();
      check("rstresp_after", 64'({bus.rsp0_valid, bus.rsp1_valid, op_count}), 64'd0);
    end

    // Saturation: preload the counter just below the limit, then complete three operations.
    do_reset();
    force dut.op_count_q = 16'hFFFE;
    #1;
    release dut.op_count_q;
    exp_count = 16'hFFFE;
    run_op(vecs[0], "sat0");
    run_op(vecs[1], "sat1");
    run_op(vecs[0], "sat2");

    // Randomized traffic against a transaction-level model.
    do_reset();
    busy = 1'b0; ptr = 1'b0; m_id = 1'b0; acc_cyc = 0;
    m_a = '0; m_b = '0; m_sel = '0; m_res = '0;
    for (int cyc = 0; cyc < 600; cyc++) begin
      v0 = ($urandom_range(0, 2) != 0);
      v1 = ($urandom_range(0, 2) != 0);
      r0 = 1'($urandom_range(0, 1));
      r1 = 1'($urandom_range(0, 1));
      bus.req0_valid = v0; bus.req0_a = $urandom(); bus.req0_b = $urandom();
      bus.req0_sel = sel_tab[$urandom_range(0, 6)];
      bus.req1_valid = v1; bus.req1_a = $urandom(); bus.req1_b = $urandom();
      bus.req1_sel = sel_tab[$urandom_range(0, 6)];
      bus.rsp0_ready = r0; bus.rsp1_ready = r1;
      #1;
      accept_now = !busy && (v0 || v1);
`ifdef ALU_ARB_FIXED_PRIO_EN
      g = !v0;
`else
      g = (v0 && v1) ? ptr : v1;
`endif
      resp_now = busy && (cyc >= acc_cyc + 2);
      exp_rdy  = accept_now ? (g ? 2'b01 : 2'b10) : 2'b00;
      exp_rv   = resp_now ? (m_id ? 2'b01 : 2'b10) : 2'b00;
      check("rnd_ready", 64'({bus.req0_ready, bus.req1_ready}), 64'(exp_rdy));
      check("rnd_rsp_valid", 64'({bus.rsp0_valid, bus.rsp1_valid}), 64'(exp_rv));
      if (resp_now) check("rnd_rsp_data", 64'({bus.rsp_carry, bus.rsp_data}), 64'(m_res));
      check("rnd_alu_a", 64'(alu_a), 64'(m_a));
      check("rnd_alu_b_sel", 64'({alu_b, alu_sel}), 64'({m_b, m_sel}));
      check("rnd_count", 64'(op_count), 64'(exp_count));
      if (accept_now) begin
        busy    = 1'b1;
        acc_cyc = cyc;
        m_id    = g;
        m_a     = g ? bus.req1_a   : bus.req0_a;
        m_b     = g ? bus.req1_b   : bus.req0_b;
        m_sel   = g ? bus.req1_sel : bus.req0_sel;
        m_res   = alu_fn(m_a, m_b, m_sel);
        ptr     = ~g;
      end else if (resp_now && (m_id ? r1 : r0)) begin
        busy      = 1'b0;
        exp_count = sat_inc(exp_count);
      end
      tick();
    end
    idle_inputs();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
